// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller between decode and ALU: load-use stall, jump flush, forward-select flags.
// Latency: one cycle from inst_id to inst_ex; stall is combinational in the same cycle.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use pair; flush squashes IF/ID once after J.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_id,
    input  logic        id_valid,
    output logic [31:0] inst_ex,
    output logic        ex_valid,
    output logic        tofwd1,
    output logic        tofwd2,
    output logic        stall,
    output logic        flush,
    output logic [15:0] hazard_cnt
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101000;
    localparam logic [5:0] OP_SLL = 6'b110010;
    localparam logic [5:0] OP_SRL = 6'b111011;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] id_dst;
    logic       id_ld;
    logic       id_jmp;
    logic       id_wr;

    logic [4:0] ex_dst;
    logic       ex_wr;
    logic       ex_ld;
    logic [4:0] mem_dst;
    logic       mem_wr;

    logic       load_use;
    logic       fwd_ok;
    logic       issue;
    logic       unused_bits;

    assign opcode = inst_id[31:26];
    assign rs     = inst_id[25:21];
    assign rt     = inst_id[20:16];
    assign rd     = inst_id[15:11];

    always_comb begin
        id_dst = 5'd0;
        id_ld  = 1'b0;
        id_jmp = 1'b0;
        case (opcode)
            OP_LW: begin
                id_dst = rt;
                id_ld  = 1'b1;
            end
            OP_SLL, OP_SRL: id_dst = rd;
            OP_J:           id_jmp = 1'b1;
            OP_SW:          id_dst = 5'd0;
            default:        id_dst = 5'd0;
        endcase
    end

    // r0 is hardwired, so a zero destination never creates a dependency
    assign id_wr    = (id_dst != 5'd0);
    assign load_use = id_valid && ex_valid && ex_ld && (ex_dst != 5'd0) &&
                      ((ex_dst == rs) || (ex_dst == rt));
    // A load in EX is never a forward source; that case is resolved by the stall
    assign fwd_ok   = ex_wr && !ex_ld && (ex_dst != 5'd0);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        issue     = 1'b0;
        case (state)
            RUN: begin
                if (load_use) begin
                    stall     = 1'b1;
                    state_nxt = STALL;
                end else if (id_valid) begin
                    issue = 1'b1;
                    if (id_jmp) state_nxt = FLUSH;
                end
            end
            STALL: begin
                issue     = id_valid;
                state_nxt = RUN;
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            flush <= 1'b0;
        end else begin
            state <= state_nxt;
            flush <= (state_nxt == FLUSH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_ex  <= 32'd0;
            ex_valid <= 1'b0;
            tofwd1   <= 1'b0;
            tofwd2   <= 1'b0;
            ex_dst   <= 5'd0;
            ex_wr    <= 1'b0;
            ex_ld    <= 1'b0;
            mem_dst  <= 5'd0;
            mem_wr   <= 1'b0;
        end else begin
            mem_dst <= ex_dst;
            mem_wr  <= ex_wr;
            if (issue) begin
                inst_ex  <= inst_id;
                ex_valid <= 1'b1;
                tofwd1   <= fwd_ok && (ex_dst == rs);
                tofwd2   <= fwd_ok && (ex_dst == rt);
                ex_dst   <= id_dst;
                ex_wr    <= id_wr;
                ex_ld    <= id_ld;
            end else begin
                inst_ex  <= 32'd0;
                ex_valid <= 1'b0;
                tofwd1   <= 1'b0;
                tofwd2   <= 1'b0;
                ex_dst   <= 5'd0;
                ex_wr    <= 1'b0;
                ex_ld    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hazard_cnt <= 16'd0;
        end else if ((stall || flush) && (hazard_cnt != 16'hFFFF)) begin
            hazard_cnt <= hazard_cnt + 16'd1;
        end
    end

    // MEM tracking is kept for the downstream write-back path, not consumed here
    assign unused_bits = ^{inst_id[10:0], mem_dst, mem_wr};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use stall, forwarding, jump flush, reset abort, saturation.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] inst_id;
    logic        id_valid;
    logic [31:0] inst_ex;
    logic        ex_valid;
    logic        tofwd1;
    logic        tofwd2;
    logic        stall;
    logic        flush;
    logic [15:0] hazard_cnt;

    int n_checks;
    int n_errors;
    int n_stalls;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .inst_id    (inst_id),
        .id_valid   (id_valid),
        .inst_ex    (inst_ex),
        .ex_valid   (ex_valid),
        .tofwd1     (tofwd1),
        .tofwd2     (tofwd2),
        .stall      (stall),
        .flush      (flush),
        .hazard_cnt (hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after the falling edge; registered outputs then reflect the last rising edge
    task automatic drive(input logic [31:0] inst, input logic vld);
        @(negedge clk);
        inst_id  = inst;
        id_valid = vld;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        inst_id  = 32'd0;
        id_valid = 1'b0;
        reset    = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_inst_ex"}, inst_ex, 32'd0);
        check({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, "_fwd"}, {30'd0, tofwd1, tofwd2}, 32'd0);
        check({tag, "_stall_flush"}, {30'd0, stall, flush}, 32'd0);
        check({tag, "_cnt"}, {16'd0, hazard_cnt}, 32'd0);
    endtask

    logic [31:0] lw_r5, lw_r0, lw_r5r5, sll_r6, sll_r4, srl_r9, sw_r9, sll_r0, j_0, j_r5, sw_a;

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_stalls = 0;
        reset    = 1'b1;
        inst_id  = 32'd0;
        id_valid = 1'b0;

        lw_r5   = enc(6'b100011, 5'd0, 5'd5, 5'd0);
        lw_r0   = enc(6'b100011, 5'd2, 5'd0, 5'd0);
        lw_r5r5 = enc(6'b100011, 5'd5, 5'd5, 5'd0);
        sll_r6  = enc(6'b110010, 5'd5, 5'd7, 5'd6);
        sll_r4  = enc(6'b110010, 5'd1, 5'd2, 5'd4);
        srl_r9  = enc(6'b111011, 5'd4, 5'd4, 5'd9);
        sw_r9   = enc(6'b101000, 5'd9, 5'd3, 5'd0);
        sll_r0  = enc(6'b110010, 5'd0, 5'd0, 5'd3);
        j_0     = enc(6'b000010, 5'd0, 5'd0, 5'd0);
        j_r5    = enc(6'b000010, 5'd5, 5'd0, 5'd0);
        sw_a    = enc(6'b101000, 5'd1, 5'd2, 5'd0);

        // Reset state
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Load-use: LW r5 then SLL reading r5
        drive(lw_r5, 1'b1);
        check("lu_no_stall_first", {31'd0, stall}, 32'd0);
        drive(sll_r6, 1'b1);
        check("lu_lw_in_ex", inst_ex, lw_r5);
        check("lu_stall", {31'd0, stall}, 32'd1);
        drive(sll_r6, 1'b1);
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bubble_inst", inst_ex, 32'd0);
        check("lu_stall_once", {31'd0, stall}, 32'd0);
        check("lu_cnt_mid", {16'd0, hazard_cnt}, 32'd1);
        drive(32'd0, 1'b0);
        check("lu_sll_issued", inst_ex, sll_r6);
        check("lu_sll_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_sll_fwd1", {31'd0, tofwd1}, 32'd0);
        check("lu_cnt", {16'd0, hazard_cnt}, 32'd1);

        // ALU-to-ALU forwarding
        do_reset();
        drive(sll_r4, 1'b1);
        drive(srl_r9, 1'b1);
        check("fw_no_stall", {31'd0, stall}, 32'd0);
        drive(sw_r9, 1'b1);
        check("fw_srl_issued", inst_ex, srl_r9);
        check("fw_srl_fwd", {30'd0, tofwd1, tofwd2}, 32'd3);
        drive(32'd0, 1'b0);
        check("fw_sw_issued", inst_ex, sw_r9);
        check("fw_sw_fwd", {30'd0, tofwd1, tofwd2}, 32'd2);
        drive(32'd0, 1'b0);
        check("idle_bubble", {31'd0, ex_valid}, 32'd0);
        check("idle_fwd", {30'd0, tofwd1, tofwd2}, 32'd0);
        check("idle_cnt", {16'd0, hazard_cnt}, 32'd0);

        // Jump flush
        do_reset();
        drive(j_0, 1'b1);
        drive(sw_a, 1'b1);
        check("j_issued", inst_ex, j_0);
        check("j_flush", {31'd0, flush}, 32'd1);
        check("j_no_stall", {31'd0, stall}, 32'd0);
        drive(sw_a, 1'b1);
        check("j_bubble", {31'd0, ex_valid}, 32'd0);
        check("j_flush_done", {31'd0, flush}, 32'd0);
        drive(32'd0, 1'b0);
        check("j_next_issue", inst_ex, sw_a);
        check("j_next_valid", {31'd0, ex_valid}, 32'd1);
        check("j_cnt", {16'd0, hazard_cnt}, 32'd1);

        // r0 load never creates a dependency
        do_reset();
        drive(lw_r0, 1'b1);
        drive(sll_r0, 1'b1);
        check("r0_no_stall", {31'd0, stall}, 32'd0);
        drive(32'd0, 1'b0);
        check("r0_issued", inst_ex, sll_r0);
        check("r0_fwd", {30'd0, tofwd1, tofwd2}, 32'd0);
        check("r0_cnt", {16'd0, hazard_cnt}, 32'd0);

        // Load-use wins over jump
        do_reset();
        drive(lw_r5, 1'b1);
        drive(j_r5, 1'b1);
        check("prio_stall", {31'd0, stall}, 32'd1);
        drive(j_r5, 1'b1);
        check("prio_bubble", {31'd0, ex_valid}, 32'd0);
        check("prio_no_flush", {31'd0, flush}, 32'd0);

        // Asynchronous reset in the middle of a STALL cycle
        do_reset();
        drive(lw_r5, 1'b1);
        drive(sll_r6, 1'b1);
        drive(sll_r6, 1'b1);
        check("rs_pre_cnt", {16'd0, hazard_cnt}, 32'd1);
        id_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check_zero("rs_stall");
        #1;
        reset = 1'b1;
        drive(sw_a, 1'b1);
        check("rs_post_no_stall", {31'd0, stall}, 32'd0);
        drive(32'd0, 1'b0);
        check("rs_post_issue", inst_ex, sw_a);
        check("rs_post_valid", {31'd0, ex_valid}, 32'd1);

        // Asynchronous reset in the middle of a FLUSH cycle
        do_reset();
        drive(j_0, 1'b1);
        drive(sw_a, 1'b1);
        check("rf_pre_flush", {31'd0, flush}, 32'd1);
        id_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        check_zero("rf_flush");
        #1;
        reset = 1'b1;
        drive(sw_a, 1'b1);
        drive(32'd0, 1'b0);
        check("rf_post_issue", inst_ex, sw_a);
        check("rf_post_flush", {31'd0, flush}, 32'd0);

        // Saturation: preload near the top, then keep generating load-use stalls
        do_reset();
        drive(32'd0, 1'b0);
        force dut.hazard_cnt = 16'hFFFC;
        #1;
        release dut.hazard_cnt;
        for (int i = 0; i < 12; i++) begin
            drive(lw_r5r5, 1'b1);
            if (stall) n_stalls++;
        end
        drive(32'd0, 1'b0);
        check("sat_events", n_stalls, 32'd6);
        check("sat_cnt", {16'd0, hazard_cnt}, 32'h0000FFFF);
        drive(32'd0, 1'b0);
        check("sat_hold", {16'd0, hazard_cnt}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
